square_bounce: RTL and testbench

SQUARE_BOUNCE -- requirements
Module: square_bounce

---
 rtl/square_bounce.sv | 156 +++++++++++++++
 tb/tb_square_bounce.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/square_bounce.sv
// square_bounce: paints a solid square over a flat background and moves it by
// SPEED pixels per axis once per frame, reflecting off the display edges.
// Every display-side output is the corresponding input delayed by one clock.
module square_bounce #(
    parameter int BPC   = 5,
    parameter int CORDW = 16,
    parameter int HRES  = 640,
    parameter int VRES  = 480,
    parameter int SIZE  = 200,
    parameter int SPEED = 2,
    parameter int X0    = 220,
    parameter int Y0    = 140,
    parameter logic [BPC-1:0] FG_R = 'h1F,
    parameter logic [BPC-1:0] FG_G = 'h1F,
    parameter logic [BPC-1:0] FG_B = 'h1F,
    parameter logic [BPC-1:0] BG_R = 'h02,
    parameter logic [BPC-1:0] BG_G = 'h06,
    parameter logic [BPC-1:0] BG_B = 'h0E
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic signed [CORDW-1:0] dx,
    input  logic signed [CORDW-1:0] dy,
    input  logic                    hsync,
    input  logic                    vsync,
    input  logic                    de,
    input  logic                    frame_start,
    input  logic                    pause,
    output logic signed [CORDW-1:0] disp_x,
    output logic signed [CORDW-1:0] disp_y,
    output logic                    disp_hsync,
    output logic                    disp_vsync,
    output logic                    disp_de,
    output logic                    disp_frame,
    output logic [BPC-1:0]          disp_r,
    output logic [BPC-1:0]          disp_g,
    output logic [BPC-1:0]          disp_b,
    output logic [7:0]              bounce_cnt
);

    // One extra bit of headroom keeps every position/limit comparison exact.
    localparam int W = CORDW + 1;
    localparam logic signed [W-1:0]     SIZE_W  = W'(SIZE);
    localparam logic signed [W-1:0]     SPEED_W = W'(SPEED);
    localparam logic signed [W-1:0]     HRES_W  = W'(HRES);
    localparam logic signed [W-1:0]     VRES_W  = W'(VRES);
    localparam logic signed [CORDW-1:0] SPEED_C = CORDW'(SPEED);

    logic signed [CORDW-1:0] sq_x, sq_y, sq_x_next, sq_y_next;
    logic                    dir_x, dir_y, dir_x_next, dir_y_next;
    logic                    hit_x, hit_y;
    logic                    move;
    logic                    in_square;
    logic signed [W-1:0]     dx_e, dy_e, sq_x_e, sq_y_e;

    // One axis of motion; returns {bounced, new direction, new position}.
    function automatic logic [CORDW+1:0] axis_step(
        input logic signed [CORDW-1:0] pos,
        input logic                    dir,
        input logic signed [W-1:0]     res
    );
        logic signed [W-1:0] pos_e;
        logic [CORDW+1:0]    r;
        pos_e = {pos[CORDW-1], pos};
        r     = {1'b0, dir, pos};
        if (dir) begin
            if (pos_e + SIZE_W + SPEED_W >= res)
                r = {1'b1, 1'b0, CORDW'(res - SIZE_W)};
            else
                r = {1'b0, 1'b1, pos + SPEED_C};
        end else begin
            if (pos_e < SPEED_W)
                r = {1'b1, 1'b1, {CORDW{1'b0}}};
            else
                r = {1'b0, 1'b0, pos - SPEED_C};
        end
        return r;
    endfunction

    assign move = frame_start && !pause;

    // Candidate next position for both axes, evaluated independently.
    always_comb begin
        {hit_x, dir_x_next, sq_x_next} = axis_step(sq_x, dir_x, HRES_W);
        {hit_y, dir_y_next, sq_y_next} = axis_step(sq_y, dir_y, VRES_W);
    end

    // Square position and direction: moves only on an unpaused frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sq_x  <= CORDW'(X0);
            sq_y  <= CORDW'(Y0);
            dir_x <= 1'b1;
            dir_y <= 1'b1;
        end else if (move) begin
            sq_x  <= sq_x_next;
            sq_y  <= sq_y_next;
            dir_x <= dir_x_next;
            dir_y <= dir_y_next;
        end
    end

    // Counts frames with any wall contact (a corner counts once), saturating.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            bounce_cnt <= 8'd0;
        else if (move && (hit_x || hit_y) && bounce_cnt != 8'hFF)
            bounce_cnt <= bounce_cnt + 8'd1;
    end

    // Pixel hit test against the position registers of this same cycle.
    always_comb begin
        dx_e      = {dx[CORDW-1], dx};
        dy_e      = {dy[CORDW-1], dy};
        sq_x_e    = {sq_x[CORDW-1], sq_x};
        sq_y_e    = {sq_y[CORDW-1], sq_y};
        in_square = (dx_e >= sq_x_e) && (dx_e < sq_x_e + SIZE_W) &&
                    (dy_e >= sq_y_e) && (dy_e < sq_y_e + SIZE_W);
    end

    // Single output stage: timing passthrough plus blanked pixel colour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_x     <= '0;
            disp_y     <= '0;
            disp_hsync <= 1'b0;
            disp_vsync <= 1'b0;
            disp_de    <= 1'b0;
            disp_frame <= 1'b0;
            disp_r     <= '0;
            disp_g     <= '0;
            disp_b     <= '0;
        end else begin
            disp_x     <= dx;
            disp_y     <= dy;
            disp_hsync <= hsync;
            disp_vsync <= vsync;
            disp_de    <= de;
            disp_frame <= frame_start;
            if (!de) begin
                disp_r <= '0;
                disp_g <= '0;
                disp_b <= '0;
            end else if (in_square) begin
                disp_r <= FG_R;
                disp_g <= FG_G;
                disp_b <= FG_B;
            end else begin
                disp_r <= BG_R;
                disp_g <= BG_G;
                disp_b <= BG_B;
            end
        end
    end

endmodule

// File: tb/tb_square_bounce.sv
// tb_square_bounce: four differently parameterised square_bounce instances
// driven with shared stimulus; pixel results go through a scoreboard queue and
// the square state is compared against a reference model every cycle.
module tb_square_bounce;

    localparam int N = 4;
    localparam int P_HRES  [N] = '{640, 640, 640, 204};
    localparam int P_SPEED [N] = '{2, 2, 2, 3};
    localparam int P_X0    [N] = '{220, 438, 438, 1};
    localparam int P_Y0    [N] = '{140, 100, 278, 0};
    localparam int VRES = 480;
    localparam int SIZE = 200;

    logic clk = 1'b0;
    logic rst_n;
    logic signed [15:0] dx, dy;
    logic hsync, vsync, de, frame_start, pause;

    logic signed [15:0] o_x [N];
    logic signed [15:0] o_y [N];
    logic o_hs [N];
    logic o_vs [N];
    logic o_de [N];
    logic o_fs [N];
    logic [4:0] o_r [N];
    logic [4:0] o_g [N];
    logic [4:0] o_b [N];
    logic [7:0] o_bc [N];
    logic signed [15:0] obs_x [N];
    logic signed [15:0] obs_y [N];
    logic obs_dirx [N];
    logic obs_diry [N];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        square_bounce #(
            .HRES (P_HRES[gi]),
            .SPEED(P_SPEED[gi]),
            .X0   (P_X0[gi]),
            .Y0   (P_Y0[gi])
        ) u_dut (
            .clk        (clk),
            .rst_n      (rst_n),
            .dx         (dx),
            .dy         (dy),
            .hsync      (hsync),
            .vsync      (vsync),
            .de         (de),
            .frame_start(frame_start),
            .pause      (pause),
            .disp_x     (o_x[gi]),
            .disp_y     (o_y[gi]),
            .disp_hsync (o_hs[gi]),
            .disp_vsync (o_vs[gi]),
            .disp_de    (o_de[gi]),
            .disp_frame (o_fs[gi]),
            .disp_r     (o_r[gi]),
            .disp_g     (o_g[gi]),
            .disp_b     (o_b[gi]),
            .bounce_cnt (o_bc[gi])
        );
        assign obs_x[gi]    = u_dut.sq_x;
        assign obs_y[gi]    = u_dut.sq_y;
        assign obs_dirx[gi] = u_dut.dir_x;
        assign obs_diry[gi] = u_dut.dir_y;
    end

    // Reference model of the square state per instance.
    int m_x [N];
    int m_y [N];
    bit m_dirx [N];
    bit m_diry [N];
    int m_bc [N];

    typedef struct {
        int x;
        int y;
        bit hs;
        bit vs;
        bit de;
        bit fs;
        logic [N-1:0][14:0] rgb;
    } exp_t;
    exp_t sb[$];

    int checks = 0;
    int errors = 0;

    localparam logic [14:0] FG = {5'h1F, 5'h1F, 5'h1F};
    localparam logic [14:0] BG = {5'h02, 5'h06, 5'h0E};

    task automatic chk(input string tag, input int idx,
                       input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d] observed %0d expected %0d", tag, idx, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < N; i++) begin
            m_x[i] = P_X0[i];
            m_y[i] = P_Y0[i];
            m_dirx[i] = 1'b1;
            m_diry[i] = 1'b1;
            m_bc[i] = 0;
        end
    endfunction

    function automatic void axis(inout int p, inout bit d, input int res,
                                 input int speed, output bit hit);
        hit = 1'b0;
        if (d) begin
            if (p + SIZE + speed >= res) begin p = res - SIZE; d = 1'b0; hit = 1'b1; end
            else p = p + speed;
        end else begin
            if (p < speed) begin p = 0; d = 1'b1; hit = 1'b1; end
            else p = p - speed;
        end
    endfunction

    function automatic void model_frame();
        bit hx, hy;
        for (int i = 0; i < N; i++) begin
            axis(m_x[i], m_dirx[i], P_HRES[i], P_SPEED[i], hx);
            axis(m_y[i], m_diry[i], VRES, P_SPEED[i], hy);
            if ((hx || hy) && m_bc[i] < 255) m_bc[i]++;
        end
    endfunction

    function automatic logic [14:0] pix(input int i, input int x, input int y, input bit de_i);
        if (!de_i) return 15'd0;
        if (x >= m_x[i] && x < m_x[i] + SIZE && y >= m_y[i] && y < m_y[i] + SIZE) return FG;
        return BG;
    endfunction

    task automatic check_state(input string tag);
        for (int i = 0; i < N; i++) begin
            chk({tag, "_sqx"}, i, obs_x[i], m_x[i]);
            chk({tag, "_sqy"}, i, obs_y[i], m_y[i]);
            chk({tag, "_dirx"}, i, obs_dirx[i], m_dirx[i]);
            chk({tag, "_diry"}, i, obs_diry[i], m_diry[i]);
            chk({tag, "_bcnt"}, i, o_bc[i], m_bc[i]);
        end
    endtask

    task automatic check_reset(input string tag);
        for (int i = 0; i < N; i++) begin
            chk({tag, "_x"}, i, o_x[i], 0);
            chk({tag, "_y"}, i, o_y[i], 0);
            chk({tag, "_hs"}, i, o_hs[i], 0);
            chk({tag, "_vs"}, i, o_vs[i], 0);
            chk({tag, "_de"}, i, o_de[i], 0);
            chk({tag, "_fs"}, i, o_fs[i], 0);
            chk({tag, "_rgb"}, i, {o_r[i], o_g[i], o_b[i]}, 0);
        end
        check_state(tag);
    endtask

    task automatic check_out();
        exp_t e;
        checks++;
        assert (sb.size() > 0) else begin
            errors++;
            $error("FAIL scoreboard_empty observed %0d expected 1", sb.size());
        end
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("disp_x", 0, o_x[0], e.x);
            chk("disp_y", 0, o_y[0], e.y);
            chk("disp_hsync", 0, o_hs[0], e.hs);
            chk("disp_vsync", 0, o_vs[0], e.vs);
            chk("disp_de", 0, o_de[0], e.de);
            chk("disp_frame", 0, o_fs[0], e.fs);
            for (int i = 0; i < N; i++)
                chk("disp_rgb", i, {o_r[i], o_g[i], o_b[i]}, e.rgb[i]);
        end
    endtask

    // One transaction: drive at the falling edge, push expectation, check
    // the registered result 1 time unit after the next rising edge.
    task automatic cycle(input int x, input int y, input bit de_i, input bit fs, input bit ps);
        exp_t e;
        dx = 16'(x);
        dy = 16'(y);
        de = de_i;
        hsync = x[1];
        vsync = y[1];
        frame_start = fs;
        pause = ps;
        e.x = x;
        e.y = y;
        e.hs = x[1];
        e.vs = y[1];
        e.de = de_i;
        e.fs = fs;
        for (int i = 0; i < N; i++) e.rgb[i] = pix(i, x, y, de_i);
        sb.push_back(e);
        @(posedge clk);
        if (rst_n && fs && !ps) model_frame();
        #1;
        check_out();
        check_state("state");
        $display("step dx=%0d dy=%0d de=%0d fs=%0d pause=%0d sq0=(%0d,%0d) bcnt=%0d/%0d/%0d/%0d",
                 x, y, de_i, fs, ps, m_x[0], m_y[0], m_bc[0], m_bc[1], m_bc[2], m_bc[3]);
        @(negedge clk);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        dx = '0; dy = '0; hsync = 0; vsync = 0; de = 0; frame_start = 0; pause = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset("reset");
        rst_n = 1'b1;

        // Pixel painting at the reset position.
        cycle(220, 140, 1, 0, 0);
        chk("rgb_corner", 0, {o_r[0], o_g[0], o_b[0]}, FG);
        cycle(219, 140, 1, 0, 0);
        chk("rgb_left", 0, {o_r[0], o_g[0], o_b[0]}, BG);
        cycle(420, 140, 1, 0, 0);
        chk("rgb_right", 0, {o_r[0], o_g[0], o_b[0]}, BG);
        cycle(419, 339, 1, 0, 0);
        chk("rgb_inner", 0, {o_r[0], o_g[0], o_b[0]}, FG);
        cycle(300, 200, 0, 0, 0);
        chk("rgb_blank", 0, {o_r[0], o_g[0], o_b[0]}, 0);
        chk("de_blank", 0, o_de[0], 0);
        chk("x_blank", 0, o_x[0], 300);

        // First frame update: straight move, right bounce, corner bounce.
        cycle(0, 0, 0, 1, 0);
        chk("f1_sqx", 0, obs_x[0], 222);
        chk("f1_sqy", 0, obs_y[0], 142);
        chk("f1_bcnt", 0, o_bc[0], 0);
        chk("f1_sqx", 1, obs_x[1], 440);
        chk("f1_dirx", 1, obs_dirx[1], 0);
        chk("f1_bcnt", 1, o_bc[1], 1);
        chk("f1_sqx", 2, obs_x[2], 440);
        chk("f1_sqy", 2, obs_y[2], 280);
        chk("f1_dirs", 2, {obs_dirx[2], obs_diry[2]}, 0);
        chk("f1_bcnt", 2, o_bc[2], 1);
        cycle(221, 141, 1, 0, 0);
        chk("rgb_moved_bg", 0, {o_r[0], o_g[0], o_b[0]}, BG);
        cycle(222, 142, 1, 0, 0);
        chk("rgb_moved_fg", 0, {o_r[0], o_g[0], o_b[0]}, FG);

        // Second frame: moving away from the walls.
        cycle(10, 10, 1, 1, 0);
        chk("f2_sqx", 1, obs_x[1], 438);
        chk("f2_sqy", 1, obs_y[1], 104);
        chk("f2_bcnt", 1, o_bc[1], 1);
        chk("f2_sqx", 3, obs_x[3], 1);

        // Third frame: instance 3 at x=1 moving left clamps to 0.
        cycle(10, 10, 1, 1, 0);
        chk("f3_sqx", 3, obs_x[3], 0);
        chk("f3_dirx", 3, obs_dirx[3], 1);
        chk("f3_bcnt", 3, o_bc[3], 2);

        // Paused frames freeze motion but keep painting.
        for (int k = 0; k < 3; k++) cycle(226, 146, 1, 1, 1);
        chk("pause_sqx", 0, obs_x[0], 226);
        chk("pause_bcnt", 3, o_bc[3], 2);

        // Asynchronous reset mid-frame, then release with a coincident frame start.
        cycle(5, 5, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        sb.delete();
        check_reset("async_rst");
        @(posedge clk);
        #1;
        check_reset("held_rst");
        @(negedge clk);
        rst_n = 1'b1;
        cycle(100, 100, 1, 1, 0);
        chk("rel_sqx", 0, obs_x[0], 222);
        chk("rel_sqy", 0, obs_y[0], 142);
        chk("rel_frame", 0, o_fs[0], 1);

        // Long run of consecutive frames with random pixels, incl. negatives.
        for (int k = 0; k < 600; k++)
            cycle(int'($urandom_range(0, 700)) - 30, int'($urandom_range(0, 540)) - 30,
                  1'($urandom_range(0, 1)), 1, 0);
        chk("sat_bcnt", 3, o_bc[3], 255);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
